// File: rtl/frontend_xbar.sv
// Receive-path crossbar: routes any ADC frontend to any DSP channel, with blanking on
// select changes, staged select updates and an overflow monitor on the settings bus.
module frontend_xbar #(
    parameter int unsigned BASE         = 0,
    parameter int unsigned NUM_IN       = 2,
    parameter int unsigned NUM_OUT      = 4,
    parameter int unsigned WIDTH        = 24,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       set_stb,
    input  logic [7:0]                 set_addr,
    input  logic [31:0]                set_data,
    input  logic [NUM_IN*WIDTH-1:0]    i_in,
    input  logic [NUM_IN*WIDTH-1:0]    q_in,
    input  logic [NUM_IN-1:0]          ovf_i_in,
    input  logic [NUM_IN-1:0]          ovf_q_in,
    input  logic [NUM_OUT-1:0]         run_in,
    output logic [NUM_OUT*WIDTH-1:0]   i_out,
    output logic [NUM_OUT*WIDTH-1:0]   q_out,
    output logic [NUM_OUT-1:0]         run_out,
    output logic [NUM_OUT-1:0]         ovf_i_out,
    output logic [NUM_OUT-1:0]         ovf_q_out,
    output logic [NUM_OUT-1:0]         switching,
    output logic [31:0]                status
);

    localparam int unsigned SEL_W      = 2 * NUM_OUT;
    localparam logic [7:0]  ADDR_SEL   = 8'(BASE);
    localparam logic [7:0]  ADDR_CTRL  = 8'(BASE + 1);
    localparam logic [7:0]  ADDR_APPLY = 8'(BASE + 2);
    // The counter is loaded one short so BLANK lasts exactly BLANK_CYCLES cycles.
    localparam logic [7:0]  BLANK_LOAD = (BLANK_CYCLES > 0) ? 8'(BLANK_CYCLES - 1) : 8'd0;

    typedef enum logic {ST_RUN, ST_BLANK} state_t;

    logic                wr_sel;
    logic                wr_ctrl;
    logic                wr_apply;
    logic                clr_ovf;
    logic [SEL_W-1:0]    shadow_reg;
    logic [SEL_W-1:0]    active_reg;
    logic [SEL_W-1:0]    active_next;
    logic                staged_reg;
    logic [NUM_IN-1:0]   ovf_vec;
    logic [NUM_IN-1:0]   sticky_reg;
    logic [NUM_IN-1:0]   sticky_next;
    logic [15:0]         cnt_reg;
    logic [15:0]         cnt_next;
    logic [NUM_OUT-1:0]  switching_vec;
    logic [31:0]         status_reg;

    logic [WIDTH-1:0]    i_src [4];
    logic [WIDTH-1:0]    q_src [4];
    logic [3:0]          ovf_i_src;
    logic [3:0]          ovf_q_src;

    assign wr_sel   = set_stb && (set_addr == ADDR_SEL);
    assign wr_ctrl  = set_stb && (set_addr == ADDR_CTRL);
    assign wr_apply = set_stb && (set_addr == ADDR_APPLY);
    assign clr_ovf  = wr_ctrl && set_data[1];

    // Pad the source set to four entries so a mute code never indexes past the inputs.
    for (genvar gi = 0; gi < 4; gi++) begin : g_src
        if (gi < NUM_IN) begin : g_real
            assign i_src[gi]     = i_in[gi*WIDTH +: WIDTH];
            assign q_src[gi]     = q_in[gi*WIDTH +: WIDTH];
            assign ovf_i_src[gi] = ovf_i_in[gi];
            assign ovf_q_src[gi] = ovf_q_in[gi];
        end else begin : g_pad
            assign i_src[gi]     = '0;
            assign q_src[gi]     = '0;
            assign ovf_i_src[gi] = 1'b0;
            assign ovf_q_src[gi] = 1'b0;
        end
    end

    always_comb begin
        active_next = active_reg;
        if (wr_sel && !staged_reg) begin
            active_next = set_data[SEL_W-1:0];
        end else if (wr_apply && staged_reg) begin
            active_next = shadow_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg <= '0;
            active_reg <= '0;
            staged_reg <= 1'b0;
        end else begin
            if (wr_sel) begin
                shadow_reg <= set_data[SEL_W-1:0];
            end
            if (wr_ctrl) begin
                staged_reg <= set_data[0];
            end
            active_reg <= active_next;
        end
    end

    // A new overflow in the clearing cycle survives the clear.
    assign ovf_vec = ovf_i_in | ovf_q_in;

    always_comb begin
        sticky_next = sticky_reg | ovf_vec;
        cnt_next    = cnt_reg;
        if (clr_ovf) begin
            sticky_next = ovf_vec;
            cnt_next    = (|ovf_vec) ? 16'd1 : 16'd0;
        end else if ((|ovf_vec) && (cnt_reg != 16'hFFFF)) begin
            cnt_next = cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= '0;
            cnt_reg    <= '0;
            status_reg <= '0;
        end else begin
            sticky_reg <= sticky_next;
            cnt_reg    <= cnt_next;
            status_reg <= {cnt_reg, 8'(switching_vec), 4'b0000, 4'(sticky_reg)};
        end
    end

    assign status = status_reg;

    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
        state_t           state_reg;
        logic [7:0]       blank_cnt_reg;
        logic [1:0]       fld_cur;
        logic [1:0]       fld_nxt;
        logic             changed;
        logic             mute;
        logic [WIDTH-1:0] i_reg;
        logic [WIDTH-1:0] q_reg;
        logic             ovf_i_reg;
        logic             ovf_q_reg;
        logic             run_reg;
        logic             switching_reg;

        assign fld_cur = active_reg[2*gi +: 2];
        assign fld_nxt = active_next[2*gi +: 2];
        assign changed = (fld_nxt != fld_cur);
        assign mute    = (32'(fld_cur) >= NUM_IN);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg     <= ST_RUN;
                blank_cnt_reg <= '0;
                i_reg         <= '0;
                q_reg         <= '0;
                ovf_i_reg     <= 1'b0;
                ovf_q_reg     <= 1'b0;
                run_reg       <= 1'b0;
                switching_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_RUN: begin
                        if (changed && (BLANK_CYCLES > 0)) begin
                            state_reg     <= ST_BLANK;
                            blank_cnt_reg <= BLANK_LOAD;
                        end
                    end
                    ST_BLANK: begin
                        if (changed) begin
                            blank_cnt_reg <= BLANK_LOAD;
                        end else if (blank_cnt_reg == 8'd0) begin
                            state_reg <= ST_RUN;
                        end else begin
                            blank_cnt_reg <= blank_cnt_reg - 8'd1;
                        end
                    end
                    default: state_reg <= ST_RUN;
                endcase

                switching_reg <= (state_reg == ST_BLANK);
                if ((state_reg == ST_BLANK) || mute) begin
                    i_reg     <= '0;
                    q_reg     <= '0;
                    ovf_i_reg <= 1'b0;
                    ovf_q_reg <= 1'b0;
                    run_reg   <= 1'b0;
                end else begin
                    i_reg     <= i_src[fld_cur];
                    q_reg     <= q_src[fld_cur];
                    ovf_i_reg <= ovf_i_src[fld_cur];
                    ovf_q_reg <= ovf_q_src[fld_cur];
                    run_reg   <= run_in[gi];
                end
            end
        end

        assign i_out[gi*WIDTH +: WIDTH] = i_reg;
        assign q_out[gi*WIDTH +: WIDTH] = q_reg;
        assign ovf_i_out[gi]            = ovf_i_reg;
        assign ovf_q_out[gi]            = ovf_q_reg;
        assign run_out[gi]              = run_reg;
        assign switching_vec[gi]        = switching_reg;
    end

    assign switching = switching_vec;

endmodule

// File: tb/tb_frontend_xbar.sv
// Scoreboard bench for frontend_xbar: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_frontend_xbar;

    localparam int NUM_IN  = 2;
    localparam int NUM_OUT = 4;
    localparam int WIDTH   = 24;
    localparam int BLANK   = 8;

    logic                     clk;
    logic                     rst_n;
    logic                     set_stb;
    logic [7:0]               set_addr;
    logic [31:0]              set_data;
    logic [NUM_IN*WIDTH-1:0]  i_in;
    logic [NUM_IN*WIDTH-1:0]  q_in;
    logic [NUM_IN-1:0]        ovf_i_in;
    logic [NUM_IN-1:0]        ovf_q_in;
    logic [NUM_OUT-1:0]       run_in;
    logic [NUM_OUT*WIDTH-1:0] i_out;
    logic [NUM_OUT*WIDTH-1:0] q_out;
    logic [NUM_OUT-1:0]       run_out;
    logic [NUM_OUT-1:0]       ovf_i_out;
    logic [NUM_OUT-1:0]       ovf_q_out;
    logic [NUM_OUT-1:0]       switching;
    logic [31:0]              status;

    frontend_xbar #(
        .BASE         (0),
        .NUM_IN       (NUM_IN),
        .NUM_OUT      (NUM_OUT),
        .WIDTH        (WIDTH),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .i_in      (i_in),
        .q_in      (q_in),
        .ovf_i_in  (ovf_i_in),
        .ovf_q_in  (ovf_q_in),
        .run_in    (run_in),
        .i_out     (i_out),
        .q_out     (q_out),
        .run_out   (run_out),
        .ovf_i_out (ovf_i_out),
        .ovf_q_out (ovf_q_out),
        .switching (switching),
        .status    (status)
    );

    // Kinds: 0 i lane, 1 q lane, 2 run bit, 3 switching vec, 4 status,
    //        5 ovf_i bit, 6 ovf_q bit, 7 run vec
    typedef struct {
        int          cyc;
        int          kind;
        int          lane;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   cyc          = 0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sbq.size());
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] get_act(input int kind, input int lane);
        logic [31:0] v;
        v = '0;
        case (kind)
            0: v = 32'(i_out[lane*WIDTH +: WIDTH]);
            1: v = 32'(q_out[lane*WIDTH +: WIDTH]);
            2: v = 32'(run_out[lane]);
            3: v = 32'(switching);
            4: v = status;
            5: v = 32'(ovf_i_out[lane]);
            6: v = 32'(ovf_q_out[lane]);
            7: v = 32'(run_out);
            default: v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        logic [31:0] act;
        int i;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].cyc == cyc) begin
                act = get_act(sbq[i].kind, sbq[i].lane);
                tests_run = tests_run + 1;
                if (act !== sbq[i].exp) begin
                    tests_failed = tests_failed + 1;
                    $display("FAIL %s cyc=%0d lane=%0d got=0x%08h expected=0x%08h",
                             sbq[i].name, cyc, sbq[i].lane, act, sbq[i].exp);
                end else begin
                    $display("[TB] ok %s cyc=%0d lane=%0d value=0x%08h",
                             sbq[i].name, cyc, sbq[i].lane, act);
                end
                sbq.delete(i);
            end else begin
                i = i + 1;
            end
        end
    end

    task automatic expect_at(input int c, input int kind, input int lane,
                             input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.lane = lane;
        e.exp  = val;
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one settings write in the current cycle; t returns that cycle.
    task automatic wr(input logic [7:0] addr, input logic [31:0] data, output int t);
        t        = cyc;
        set_stb  = 1'b1;
        set_addr = addr;
        set_data = data;
        tick();
        set_stb  = 1'b0;
        set_addr = '0;
        set_data = '0;
    endtask

    initial begin
        int t;
        rst_n    = 1'b0;
        set_stb  = 1'b0;
        set_addr = '0;
        set_data = '0;
        i_in     = {24'h000222, 24'h000111};
        q_in     = {24'h000BBB, 24'h000AAA};
        ovf_i_in = '0;
        ovf_q_in = '0;
        run_in   = 4'b1011;

        repeat (3) tick();
        tests_run = tests_run + 1;
        if ((i_out !== '0) || (switching !== '0) || (status !== 32'h0)) begin
            tests_failed = tests_failed + 1;
            $display("FAIL direct_reset_hold i_out=0x%0h switching=0x%0h status=0x%08h",
                     i_out, switching, status);
        end else begin
            $display("[TB] ok direct_reset_hold cyc=%0d", cyc);
        end
        expect_at(cyc, 0, 0, 32'h0, "reset_i0");
        expect_at(cyc, 3, 0, 32'h0, "reset_switching");
        expect_at(cyc, 4, 0, 32'h0, "reset_status");
        expect_at(cyc, 7, 0, 32'h0, "reset_run");
        tick();
        rst_n = 1'b1;
        t = cyc;
        for (int k = 0; k < NUM_OUT; k++) expect_at(t + 1, 0, k, 32'h000111, "route_in0_i");
        expect_at(t + 1, 1, 3, 32'h000AAA, "route_in0_q");
        expect_at(t + 1, 7, 0, 32'hB, "run_follow");
        expect_at(t + 2, 4, 0, 32'h0, "status_idle");
        tick();
        tests_run = tests_run + 1;
        if (i_out !== {NUM_OUT{24'h000111}}) begin
            tests_failed = tests_failed + 1;
            $display("FAIL direct_route_in0 i_out=0x%0h", i_out);
        end else begin
            $display("[TB] ok direct_route_in0 cyc=%0d", cyc);
        end

        // One-cycle data path latency
        t = cyc;
        i_in[23:0] = 24'h123456;
        expect_at(t + 1, 0, 2, 32'h123456, "latency_new");
        tick();
        i_in[23:0] = 24'h000111;
        expect_at(t + 2, 0, 2, 32'h000111, "latency_restore");
        tick();

        // Immediate switch of lane0 to input1
        wr(8'd0, 32'h1, t);
        expect_at(t + 1, 0, 0, 32'h000111, "imm_pre_blank");
        expect_at(t + 2, 0, 0, 32'h0, "imm_blank_first");
        expect_at(t + 2, 3, 0, 32'h1, "imm_sw_first");
        expect_at(t + 5, 2, 0, 32'h0, "imm_run_gated");
        expect_at(t + 5, 0, 1, 32'h000111, "imm_lane1_untouched");
        expect_at(t + 9, 0, 0, 32'h0, "imm_blank_last");
        expect_at(t + 9, 3, 0, 32'h1, "imm_sw_last");
        expect_at(t + 10, 0, 0, 32'h000222, "imm_new_src");
        expect_at(t + 10, 3, 0, 32'h0, "imm_sw_done");
        expect_at(t + 10, 2, 0, 32'h1, "imm_run_back");
        repeat (12) tick();

        wr(8'd0, 32'h0, t);
        expect_at(t + 10, 0, 0, 32'h000111, "imm_back_in0");
        repeat (12) tick();

        // Staged mode: shadow write has no effect until apply
        wr(8'd1, 32'h1, t);
        wr(8'd0, 32'h55, t);
        expect_at(t + 2, 3, 0, 32'h0, "stg_no_sw");
        expect_at(t + 2, 0, 1, 32'h000111, "stg_no_change");
        repeat (4) tick();
        wr(8'd2, 32'h0, t);
        expect_at(t + 1, 0, 1, 32'h000111, "stg_pre_apply");
        expect_at(t + 2, 3, 0, 32'hF, "stg_all_blank");
        expect_at(t + 2, 0, 3, 32'h0, "stg_lane3_blank");
        expect_at(t + 9, 3, 0, 32'hF, "stg_blank_last");
        expect_at(t + 10, 3, 0, 32'h0, "stg_sw_done");
        expect_at(t + 10, 0, 3, 32'h000222, "stg_lane3_in1");
        expect_at(t + 10, 1, 0, 32'h000BBB, "stg_lane0_q_in1");
        repeat (12) tick();

        // Apply with an unchanged shadow: no transition
        wr(8'd2, 32'h0, t);
        expect_at(t + 2, 3, 0, 32'h0, "apply_same_no_sw");
        expect_at(t + 2, 0, 2, 32'h000222, "apply_same_data");
        repeat (3) tick();

        // Mute lane0 in immediate mode
        wr(8'd1, 32'h0, t);
        wr(8'd0, 32'h57, t);
        expect_at(t + 2, 3, 0, 32'h1, "mute_sw");
        expect_at(t + 5, 0, 1, 32'h000222, "mute_lane1_untouched");
        expect_at(t + 10, 0, 0, 32'h0, "mute_i");
        expect_at(t + 10, 1, 0, 32'h0, "mute_q");
        expect_at(t + 10, 3, 0, 32'h0, "mute_sw_done");
        expect_at(t + 10, 7, 0, 32'hA, "mute_run");
        expect_at(t + 12, 2, 0, 32'h0, "mute_run_hold");
        repeat (12) tick();

        // Overflow pulse on input1 for three cycles
        t = cyc;
        ovf_q_in = 2'b10;
        expect_at(t + 1, 6, 1, 32'h1, "ovf_route_lane1");
        expect_at(t + 1, 6, 0, 32'h0, "ovf_muted_lane0");
        expect_at(t + 2, 4, 0, 32'h0001_0002, "ovf_status_1");
        expect_at(t + 4, 4, 0, 32'h0003_0002, "ovf_status_3");
        expect_at(t + 5, 4, 0, 32'h0003_0002, "ovf_status_hold");
        repeat (3) tick();
        ovf_q_in = 2'b00;
        repeat (3) tick();

        wr(8'd1, 32'h2, t);
        expect_at(t + 2, 4, 0, 32'h0, "ovf_clear");
        repeat (2) tick();

        // Long overflow saturates the counter
        ovf_i_in = 2'b01;
        repeat (65540) tick();
        expect_at(cyc, 4, 0, 32'hFFFF_0001, "ovf_saturate");
        expect_at(cyc + 1, 4, 0, 32'hFFFF_0001, "ovf_saturate_hold");
        tick();
        // Clear coinciding with an overflow leaves cnt=1
        wr(8'd1, 32'h2, t);
        ovf_i_in = 2'b00;
        expect_at(t + 2, 4, 0, 32'h0001_0001, "ovf_clear_race");
        expect_at(t + 3, 4, 0, 32'h0001_0001, "ovf_clear_race_hold");
        repeat (3) tick();

        // Reset during a blank
        wr(8'd0, 32'h54, t);
        expect_at(t + 2, 3, 0, 32'h1, "rst_pre_blank");
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        tests_run = tests_run + 1;
        if ((switching !== '0) || (i_out !== '0)) begin
            tests_failed = tests_failed + 1;
            $display("FAIL direct_async_reset switching=0x%0h i_out=0x%0h", switching, i_out);
        end else begin
            $display("[TB] ok direct_async_reset cyc=%0d", cyc);
        end
        expect_at(t + 5, 0, 1, 32'h0, "rst_async_i");
        expect_at(t + 5, 3, 0, 32'h0, "rst_async_sw");
        expect_at(t + 5, 4, 0, 32'h0, "rst_async_status");
        expect_at(t + 5, 7, 0, 32'h0, "rst_async_run");
        tick();
        tick();
        rst_n = 1'b1;
        expect_at(t + 8, 0, 0, 32'h000111, "rst_lane0_in0");
        expect_at(t + 8, 0, 1, 32'h000111, "rst_lane1_in0");
        expect_at(t + 8, 3, 0, 32'h0, "rst_no_sw");
        expect_at(t + 10, 3, 0, 32'h0, "rst_no_sw_later");
        expect_at(t + 8, 7, 0, 32'hB, "rst_run");
        expect_at(t + 10, 1, 0, 32'h000AAA, "rst_lane0_q");
        repeat (6) tick();

        while (sbq.size() > 0) begin
            tests_run    = tests_run + 1;
            tests_failed = tests_failed + 1;
            $display("FAIL %s never checked: due cyc=%0d now=%0d expected=0x%08h",
                     sbq[0].name, sbq[0].cyc, cyc, sbq[0].exp);
            sbq.delete(0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
